// File: rtl/dem_pkg.sv
// Shared constants, types and the thermometer helper for the DWA encoder.
package dem_pkg;

    localparam int CODE_WIDTH   = 3;
    localparam int NUM_ELEMENTS = 2 ** CODE_WIDTH;
    // The pointer addresses one of NUM_ELEMENTS elements, so it is as wide as the code.
    localparam int PTR_WIDTH    = CODE_WIDTH;

    typedef logic [CODE_WIDTH-1:0]   code_t;
    typedef logic [NUM_ELEMENTS-1:0] sel_t;
    typedef logic [PTR_WIDTH-1:0]    ptr_t;

    // Thermometer code: the lowest `code` bits set, starting at element 0.
    function automatic sel_t therm_encode(input code_t code);
        sel_t therm;
        therm = '0;
        for (int k = 0; k < NUM_ELEMENTS; k++) begin
            if (k < int'(code)) begin
                therm[k] = 1'b1;
            end
        end
        return therm;
    endfunction

endpackage : dem_pkg

// File: rtl/dwa_encoder_if.sv
// Quantizer-side code stream and DAC-side select vector of the DWA encoder.
interface dwa_encoder_if;
    import dem_pkg::*;

    code_t code_i;
    logic  valid_i;
    logic  dem_en_i;
    sel_t  sel_o;
    logic  valid_o;
    ptr_t  ptr_o;
    logic  wrap_o;

    // Upstream driver of codes; observes the select vector.
    modport master (
        output code_i, valid_i, dem_en_i,
        input  sel_o, valid_o, ptr_o, wrap_o
    );

    // The encoder itself.
    modport slave (
        input  code_i, valid_i, dem_en_i,
        output sel_o, valid_o, ptr_o, wrap_o
    );

endinterface : dwa_encoder_if

// File: rtl/dwa_rotator.sv
// Combinational DWA core: thermometer(code) rotated left by the pointer,
// plus the pointer advance and wrap detection. Bypass gives a plain
// thermometer and parks the pointer at element 0.
module dwa_rotator
    import dem_pkg::*;
(
    input  code_t code_i,
    input  ptr_t  ptr_i,
    input  logic  dem_en_i,
    output sel_t  sel_next_o,
    output ptr_t  ptr_next_o,
    output logic  wrap_o
);

    sel_t                      therm;
    logic [2*NUM_ELEMENTS-1:0] rot_dbl;
    logic [PTR_WIDTH:0]        ptr_sum;

    // Rotate and advance; the carry out of the widened sum is the wrap flag.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sel_next_o = '0;
        ptr_next_o = '0;
        wrap_o     = 1'b0;

        therm   = therm_encode(code_i);
        // Shifting a doubled copy and keeping the upper half is a rotate-left by ptr_i.
        rot_dbl = {therm, therm} << ptr_i;
        ptr_sum = {1'b0, ptr_i} + {1'b0, code_i};

        if (dem_en_i) begin
            sel_next_o = rot_dbl[2*NUM_ELEMENTS-1:NUM_ELEMENTS];
            ptr_next_o = ptr_sum[PTR_WIDTH-1:0];
            wrap_o     = ptr_sum[PTR_WIDTH];
        end else begin
            sel_next_o = therm;
        end
    end

endmodule : dwa_rotator

// File: rtl/dwa_encoder.sv
// DWA element selector between the 3-bit quantizer and the unit-element DAC.
// One-cycle latency; holds the output registers, the rotation pointer and
// the valid/reset handling around the combinational rotator.
module dwa_encoder
    import dem_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    dwa_encoder_if.slave bus
);

    sel_t sel_q,   sel_d;
    ptr_t ptr_q,   ptr_d;
    logic valid_q, valid_d;
    logic wrap_q,  wrap_d;

    sel_t rot_sel;
    ptr_t rot_ptr;
    logic rot_wrap;

    dwa_rotator u_rotator (
        .code_i     (bus.code_i),
        .ptr_i      (ptr_q),
        .dem_en_i   (bus.dem_en_i),
        .sel_next_o (rot_sel),
        .ptr_next_o (rot_ptr),
        .wrap_o     (rot_wrap)
    );

    // Accept the rotator result only for a valid code; idle cycles hold the pointer.
    always_comb begin
        sel_d   = '0;
        ptr_d   = ptr_q;
        wrap_d  = 1'b0;
        valid_d = bus.valid_i;
        if (bus.valid_i) begin
            sel_d  = rot_sel;
            ptr_d  = rot_ptr;
            wrap_d = rot_wrap;
        end
    end

    // Output and pointer registers; synchronous reset drops any in-flight code.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_ni) begin
            sel_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.sel_o   = sel_q;
    assign bus.valid_o = valid_q;
    assign bus.ptr_o   = ptr_q;
    assign bus.wrap_o  = wrap_q;

endmodule : dwa_encoder

// File: tb/tb_dwa_encoder.sv
// Directed and random checks of dwa_encoder through a scoreboard queue.
module tb_dwa_encoder;
    import dem_pkg::*;

    typedef struct packed {
        sel_t sel;
        logic valid;
        ptr_t ptr;
        logic wrap;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni;

    dwa_encoder_if bus ();

    dwa_encoder dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    exp_t sb[$];
    int   n_vectors     = 0;
    int   n_miscompares = 0;

    // Reference model state for the random soak.
    int   m_ptr = 0;
    int   usage[NUM_ELEMENTS];
    int   cum_sum = 0;

    function automatic exp_t mk(input sel_t s, input logic v, input ptr_t p, input logic w);
        exp_t e;
        e.sel = s; e.valid = v; e.ptr = p; e.wrap = w;
        return e;
    endfunction

    // Independent model: walk n elements from the pointer one at a time.
    function automatic exp_t model_step(input logic v, input code_t c);
        exp_t e;
        int   n;
        e = mk('0, v, ptr_t'(m_ptr), 1'b0);
        n = int'(c);
        if (v) begin
            for (int i = 0; i < n; i++) e.sel[(m_ptr + i) % NUM_ELEMENTS] = 1'b1;
            e.wrap = (m_ptr + n >= NUM_ELEMENTS);
            m_ptr  = (m_ptr + n) % NUM_ELEMENTS;
            e.ptr  = ptr_t'(m_ptr);
        end
        return e;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        e = sb.pop_front();
        n_vectors++;
        assert (bus.valid_o === e.valid) else begin
            n_miscompares++;
            $error("FAIL %s valid_o observed %b expected %b", tag, bus.valid_o, e.valid);
        end
        n_vectors++;
        assert (bus.sel_o === e.sel) else begin
            n_miscompares++;
            $error("FAIL %s sel_o observed %b expected %b", tag, bus.sel_o, e.sel);
        end
        n_vectors++;
        assert (bus.ptr_o === e.ptr) else begin
            n_miscompares++;
            $error("FAIL %s ptr_o observed %0d expected %0d", tag, bus.ptr_o, e.ptr);
        end
        n_vectors++;
        assert (bus.wrap_o === e.wrap) else begin
            n_miscompares++;
            $error("FAIL %s wrap_o observed %b expected %b", tag, bus.wrap_o, e.wrap);
        end
    endtask

    // Drive one cycle away from the clock edge, push its expectation, compare after the edge.
    task automatic step(input logic rst, input logic v, input code_t c, input logic en,
                        input exp_t e, input string tag);
        @(negedge clk_i);
        rst_ni       = rst;
        bus.valid_i  = v;
        bus.code_i   = c;
        bus.dem_en_i = en;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        check_out(tag);
    endtask

    initial begin
        exp_t  e;
        logic  v;
        code_t c;
        int    mx, mn;

        rst_ni       = 1'b0;
        bus.valid_i  = 1'b0;
        bus.code_i   = '0;
        bus.dem_en_i = 1'b1;

        // Reset held two cycles, then idle.
        step(1'b0, 1'b0, 3'd0, 1'b1, mk(8'h00, 0, 3'd0, 0), "reset0");
        step(1'b0, 1'b0, 3'd0, 1'b1, mk(8'h00, 0, 3'd0, 0), "reset1");
        step(1'b1, 1'b0, 3'd0, 1'b1, mk(8'h00, 0, 3'd0, 0), "idle0");
        step(1'b1, 1'b0, 3'd0, 1'b1, mk(8'h00, 0, 3'd0, 0), "idle1");

        // DWA rotation, including two wraps past element 7.
        step(1'b1, 1'b1, 3'd3, 1'b1, mk(8'b00000111, 1, 3'd3, 0), "dwa3");
        step(1'b1, 1'b1, 3'd4, 1'b1, mk(8'b01111000, 1, 3'd7, 0), "dwa4");
        step(1'b1, 1'b1, 3'd2, 1'b1, mk(8'b10000001, 1, 3'd1, 1), "dwa2_wrap");
        step(1'b1, 1'b1, 3'd7, 1'b1, mk(8'b11111110, 1, 3'd0, 1), "dwa7_wrap");

        // Zero code and idle gaps hold the pointer.
        step(1'b1, 1'b1, 3'd3, 1'b1, mk(8'b00000111, 1, 3'd3, 0), "to_ptr3");
        step(1'b1, 1'b1, 3'd0, 1'b1, mk(8'b00000000, 1, 3'd3, 0), "zero_code");
        step(1'b1, 1'b0, 3'd5, 1'b1, mk(8'b00000000, 0, 3'd3, 0), "gap0");
        step(1'b1, 1'b0, 3'd7, 1'b1, mk(8'b00000000, 0, 3'd3, 0), "gap1");
        step(1'b1, 1'b0, 3'd2, 1'b1, mk(8'b00000000, 0, 3'd3, 0), "gap2");
        step(1'b1, 1'b1, 3'd2, 1'b1, mk(8'b00011000, 1, 3'd5, 0), "after_gap");

        // Bypass gives a thermometer and parks the pointer; re-enable restarts at 0.
        step(1'b1, 1'b1, 3'd5, 1'b0, mk(8'b00011111, 1, 3'd0, 0), "bypass5");
        step(1'b1, 1'b1, 3'd1, 1'b1, mk(8'b00000001, 1, 3'd1, 0), "reenable1");
        step(1'b1, 1'b1, 3'd0, 1'b0, mk(8'b00000000, 1, 3'd0, 0), "bypass0");

        // Reset mid-stream discards the concurrent valid code.
        step(1'b1, 1'b1, 3'd6, 1'b1, mk(8'b00111111, 1, 3'd6, 0), "six_a");
        step(1'b1, 1'b1, 3'd6, 1'b1, mk(8'b11001111, 1, 3'd4, 1), "six_b_wrap");
        step(1'b0, 1'b1, 3'd3, 1'b1, mk(8'b00000000, 0, 3'd0, 0), "mid_reset");
        step(1'b1, 1'b1, 3'd3, 1'b1, mk(8'b00000111, 1, 3'd3, 0), "post_reset");

        // Random soak against the model, with popcount and usage-balance checks.
        step(1'b0, 1'b0, 3'd0, 1'b1, mk(8'h00, 0, 3'd0, 0), "soak_reset");
        m_ptr   = 0;
        cum_sum = 0;
        foreach (usage[k]) usage[k] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            c = code_t'($urandom_range(0, NUM_ELEMENTS - 1));
            e = model_step(v, c);
            step(1'b1, v, c, 1'b1, e, "soak");
            if (v) begin
                n_vectors++;
                assert ($countones(bus.sel_o) === int'(c)) else begin
                    n_miscompares++;
                    $error("FAIL soak_popcount observed %0d expected %0d", $countones(bus.sel_o), c);
                end
                for (int k = 0; k < NUM_ELEMENTS; k++) usage[k] += int'(bus.sel_o[k]);
                cum_sum += int'(c);
                if (cum_sum % NUM_ELEMENTS == 0) begin
                    mx = usage[0];
                    mn = usage[0];
                    for (int k = 1; k < NUM_ELEMENTS; k++) begin
                        if (usage[k] > mx) mx = usage[k];
                        if (usage[k] < mn) mn = usage[k];
                    end
                    n_vectors++;
                    assert (mx - mn <= 1) else begin
                        n_miscompares++;
                        $error("FAIL soak_balance observed spread %0d expected at most 1", mx - mn);
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_dwa_encoder
